// File: rtl/gate_sequencer_pkg.sv
// Shared gate encodings, descriptor layout and sequencer states for the
// gate program store/issue path.
package qcm_gate_pkg;

   localparam logic [2:0] GATE_H    = 3'd0;
   localparam logic [2:0] GATE_S    = 3'd1;
   localparam logic [2:0] GATE_CNOT = 3'd2;
   localparam logic [2:0] GATE_MEAS = 3'd3;
   localparam logic [2:0] GATE_CPS  = 3'd4;
   localparam logic [2:0] GATE_TOF  = 3'd5;

   localparam int PHASE_W = 5;

   typedef struct packed {
      logic [2:0]         gtype;
      logic [PHASE_W-1:0] phase_idx;
      logic [31:0]        qpos;
      logic [31:0]        qpos2;
      logic [31:0]        qpos3;
   } gate_info_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY,
      ST_RUN
   } seq_state_t;

   function automatic logic is_nonstabilizer(input logic [2:0] t);
      return t > GATE_MEAS;
   endfunction

endpackage

// File: rtl/gate_sequencer_if.sv
// Host-side program load channel: valid/ready beats carrying one gate each.
interface gate_sequencer_if #(
   parameter int phase_lookup = 5
);
   logic                    load_valid;
   logic                    load_ready;
   logic [2:0]              load_gate_type;
   logic [phase_lookup-1:0] load_phase_shift_index;
   logic [31:0]             load_qubit_pos;
   logic [31:0]             load_qubit_pos2;
   logic [31:0]             load_qubit_pos3;
   logic                    load_last;

   modport master (
      output load_valid, load_gate_type, load_phase_shift_index,
             load_qubit_pos, load_qubit_pos2, load_qubit_pos3, load_last,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_gate_type, load_phase_shift_index,
             load_qubit_pos, load_qubit_pos2, load_qubit_pos3, load_last,
      output load_ready
   );
endinterface

// File: rtl/gate_sequencer_mem.sv
// Gate program register file: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module gate_program_mem
   import qcm_gate_pkg::*;
#(
   parameter  int max_gates = 64,
   localparam int IW        = (max_gates > 1) ? $clog2(max_gates) : 1
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [IW-1:0] i_waddr,
   input  gate_info_t    i_wdata,
   input  logic [IW-1:0] i_raddr,
   output gate_info_t    o_rdata
);

   gate_info_t r_mem [max_gates];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gate_sequencer.sv
// Loads a gate program from the host, then issues one gate per controller
// advance pulse and counts final output beats to signal run completion.
module gate_sequencer
   import qcm_gate_pkg::*;
#(
   parameter  int num_qubit    = 3,
   parameter  int phase_lookup = PHASE_W,
   parameter  int max_gates    = 64,
   localparam int AW           = $clog2(max_gates + 1),
   localparam int IW           = (max_gates > 1) ? $clog2(max_gates) : 1,
   localparam int BW           = $clog2(num_qubit + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   gate_sequencer_if.slave         load_if,
   input  logic                    start,
   input  logic                    clear,
   input  logic                    update_gate_info,
   input  logic                    valid_out,
   output logic [2:0]              gate_type,
   output logic [phase_lookup-1:0] phase_shift_index,
   output logic [31:0]             qubit_pos,
   output logic [31:0]             qubit_pos2,
   output logic [31:0]             qubit_pos3,
   output logic                    final_gate,
   output logic                    busy,
   output logic                    done,
   output logic [AW-1:0]           num_gates,
   output logic                    err_type,
   output logic                    err_overrun
);

   seq_state_t       r_state;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_num_gates;
   logic [BW-1:0]    r_beats;
   logic             r_done;
   logic             r_err_type;
   logic             r_err_overrun;

   logic             w_load_ready;
   logic             w_accept;
   logic             w_bad_type;
   logic             w_we;
   logic [AW-1:0]    w_stored;
   logic             w_final;
   logic [IW-1:0]    w_raddr;
   gate_info_t       w_wdata;
   gate_info_t       w_rdata;

   // Masked by rst so every output reads 0 while reset is held.
   assign w_load_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_LOAD))
                         && (r_wr_ptr < AW'(max_gates));
   assign w_accept     = load_if.load_valid && w_load_ready;
   assign w_bad_type   = load_if.load_gate_type > GATE_TOF;
   assign w_we         = w_accept && !w_bad_type && !clear;
   assign w_stored     = w_bad_type ? r_wr_ptr : r_wr_ptr + AW'(1);
   assign w_final      = (r_state == ST_RUN) && (r_rd_ptr == r_num_gates);
   assign w_raddr      = IW'((r_rd_ptr < r_num_gates) ? r_rd_ptr : r_num_gates - AW'(1));

   assign w_wdata.gtype     = load_if.load_gate_type;
   assign w_wdata.phase_idx = load_if.load_phase_shift_index;
   assign w_wdata.qpos      = load_if.load_qubit_pos;
   assign w_wdata.qpos2     = load_if.load_qubit_pos2;
   assign w_wdata.qpos3     = load_if.load_qubit_pos3;

   gate_program_mem #(
      .max_gates (max_gates)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (IW'(r_wr_ptr)),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_num_gates   <= '0;
         r_beats       <= '0;
         r_done        <= 1'b0;
         r_err_type    <= 1'b0;
         r_err_overrun <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (clear) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_num_gates   <= '0;
            r_beats       <= '0;
            r_err_type    <= 1'b0;
            r_err_overrun <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE, ST_LOAD: begin
                  if (w_accept) begin
                     if (w_bad_type) begin
                        r_err_type <= 1'b1;
                     end else begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_state  <= ST_LOAD;
                     end
                     // A dropped beat still closes the program when it carries last.
                     if (load_if.load_last) begin
                        r_num_gates <= w_stored;
                        r_state     <= (w_stored != '0) ? ST_READY : ST_IDLE;
                     end
                  end
               end
               ST_READY: begin
                  if (start) begin
                     r_rd_ptr <= '0;
                     r_beats  <= '0;
                     r_state  <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (update_gate_info) begin
                     if (r_rd_ptr < r_num_gates) r_rd_ptr <= r_rd_ptr + AW'(1);
                     else                        r_err_overrun <= 1'b1;
                  end
                  if (valid_out && w_final) begin
                     if (r_beats == BW'(num_qubit - 1)) begin
                        r_beats <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_READY;
                     end else begin
                        r_beats <= r_beats + BW'(1);
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      gate_type         = '0;
      phase_shift_index = '0;
      qubit_pos         = '0;
      qubit_pos2        = '0;
      qubit_pos3        = '0;
      if (r_state == ST_RUN) begin
         gate_type         = w_rdata.gtype;
         phase_shift_index = w_rdata.phase_idx;
         qubit_pos         = w_rdata.qpos;
         qubit_pos2        = w_rdata.qpos2;
         qubit_pos3        = w_rdata.qpos3;
      end
   end

   assign load_if.load_ready = w_load_ready;
   assign final_gate         = w_final;
   assign busy               = (r_state == ST_RUN);
   assign done               = r_done;
   assign num_gates          = r_num_gates;
   assign err_type           = r_err_type;
   assign err_overrun        = r_err_overrun;

endmodule
